mdu_iter: RTL

- Parametrised multiply/divide unit for the alpha execute pipe. It replaces the separate multiplier and divider instances and the done-edge commit logic with one block that has a valid/ready request handshake and a one-cycle HILO commit pulse.
- Adds a pipelined multiplier of configurable depth, a radix-2 iterative divider, MADD/MSUB accumulation, flush cancellation and defined corner-case results.
- Sits between issue/operand read and the HILO register. Its busy output drives the pipeline stall.

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_div_core.sv | 83 ++++++++
 rtl/mdu_iter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative multiply/divide unit.
// Opcode encodings are fixed because issue logic drives them as raw 4-bit codes.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NOP = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        MADD    = 4'd3,
        MADDU   = 4'd4,
        MSUB    = 4'd5,
        MSUBU   = 4'd6,
        MUL     = 4'd7,
        DIV     = 4'd8,
        DIVU    = 4'd9
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } mdu_state_t;

    function automatic logic is_signed(input mdu_op_t op);
        return (op == MULT) || (op == MADD) || (op == MSUB) || (op == MUL) || (op == DIV);
    endfunction

    function automatic logic is_mul_op(input mdu_op_t op);
        return (op == MULT) || (op == MULTU) || (op == MADD) || (op == MADDU) ||
               (op == MSUB) || (op == MSUBU) || (op == MUL);
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Dividend bits shift out of the top of r_quo while quotient bits shift in at the bottom.
module mdu_div_core #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_cancel,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);
    localparam int CW = $clog2(XLEN + 1);

    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;

    logic [CW-1:0]   w_lzc;
    logic [CW-1:0]   w_iters;
    logic [CW-1:0]   w_shift;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;

    always_comb begin
        w_lzc = CW'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (i_dividend[i]) w_lzc = CW'(XLEN - 1 - i);
        end
        if (EARLY_OUT) begin
            w_iters = (w_lzc == CW'(XLEN)) ? CW'(1) : CW'(XLEN) - w_lzc;
        end else begin
            w_iters = CW'(XLEN);
        end
        w_shift = CW'(XLEN) - w_iters;
    end

    // remainder < divisor always holds, so the XLEN+1 bit difference sign is the borrow
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_ge     = ~w_diff[XLEN];

    always_ff @(posedge clk) begin
        if (rst || i_cancel) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= w_iters;
                r_quo  <= i_dividend << w_shift;
                r_rem  <= '0;
                r_div  <= i_divisor;
            end else if (r_busy) begin
                r_quo <= {r_quo[XLEN-2:0], w_ge};
                r_rem <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_quot = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit: pipelined multiplier with MADD/MSUB accumulate and an
// iterative divider, one op in flight, single-cycle HILO (and GPR for MUL) commit.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MUL_STAGES    = 3,
    parameter bit DIV_EARLY_OUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic [2*XLEN-1:0] src_hilo,
    output logic              busy_o,
    output logic              hilo_wen,
    output logic [2*XLEN-1:0] hilo_result,
    output logic              gpr_wen,
    output logic [XLEN-1:0]   gpr_result
);
    localparam int HW = 2 * XLEN;

    mdu_state_t                    r_state;
    mdu_op_t                       r_op;
    logic [XLEN-1:0]               r_a;
    logic [XLEN-1:0]               r_b;
    logic [HW-1:0]                 r_hilo;
    logic [HW-1:0]                 r_hilo_result;
    logic [XLEN-1:0]               r_gpr_result;
    logic                          r_hilo_wen;
    logic                          r_gpr_wen;
    logic [MUL_STAGES:1]           r_vld_pipe;
    logic [MUL_STAGES-1:0][HW-1:0] r_prod;

    mdu_op_t         w_op;
    logic            w_sg;
    logic            w_accept;
    logic            w_mul_go;
    logic            w_div_go;
    logic [HW-1:0]   w_ma;
    logic [HW-1:0]   w_mb;
    logic [HW-1:0]   w_prod;
    logic [HW-1:0]   w_mul_res;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_done;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [HW-1:0]   w_div_res;

    assign w_op     = mdu_op_t'(req_op);
    assign w_sg     = is_signed(w_op);
    assign w_accept = (r_state == IDLE) && req_valid && !flush_i &&
                      (is_mul_op(w_op) || is_div_op(w_op));
    assign w_mul_go = w_accept && is_mul_op(w_op);
    assign w_div_go = w_accept && is_div_op(w_op);

    // Operands are extended to the full product width so the low 2*XLEN bits
    // of an unsigned multiply give the right answer for signed ops too.
    assign w_ma   = {{XLEN{w_sg & src_a[XLEN-1]}}, src_a};
    assign w_mb   = {{XLEN{w_sg & src_b[XLEN-1]}}, src_b};
    assign w_prod = w_ma * w_mb;

    always_comb begin
        w_mul_res = r_prod[MUL_STAGES-1];
        case (r_op)
            MADD, MADDU: w_mul_res = r_hilo + r_prod[MUL_STAGES-1];
            MSUB, MSUBU: w_mul_res = r_hilo - r_prod[MUL_STAGES-1];
            default:     w_mul_res = r_prod[MUL_STAGES-1];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_prod     <= '0;
        end else begin
            r_prod[0]     <= w_prod;
            r_vld_pipe[1] <= w_mul_go;
            for (int k = 1; k < MUL_STAGES; k++) begin
                r_prod[k]       <= r_prod[k-1];
                r_vld_pipe[k+1] <= r_vld_pipe[k];
            end
            if (flush_i) r_vld_pipe <= '0;
        end
    end

    assign w_mag_a = (w_sg && src_a[XLEN-1]) ? -src_a : src_a;
    assign w_mag_b = (w_sg && src_b[XLEN-1]) ? -src_b : src_b;

    mdu_div_core #(
        .XLEN      (XLEN),
        .EARLY_OUT (DIV_EARLY_OUT)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_go),
        .i_cancel   (flush_i),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Divide by zero is forced here: the core's magnitude answer would be
    // sign-corrected into something other than all-ones / dividend.
    assign w_a_neg = is_signed(r_op) & r_a[XLEN-1];
    assign w_b_neg = is_signed(r_op) & r_b[XLEN-1];

    always_comb begin
        if (r_b == '0) begin
            w_div_res = {r_a, {XLEN{1'b1}}};
        end else begin
            w_div_res = {(w_a_neg ? -w_rem : w_rem),
                         ((w_a_neg ^ w_b_neg) ? -w_quot : w_quot)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_op          <= MDU_NOP;
            r_a           <= '0;
            r_b           <= '0;
            r_hilo        <= '0;
            r_hilo_result <= '0;
            r_gpr_result  <= '0;
            r_hilo_wen    <= 1'b0;
            r_gpr_wen     <= 1'b0;
        end else begin
            r_hilo_wen <= 1'b0;
            r_gpr_wen  <= 1'b0;
            if (flush_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_op    <= w_op;
                            r_a     <= src_a;
                            r_b     <= src_b;
                            r_hilo  <= src_hilo;
                            r_state <= is_mul_op(w_op) ? MUL_BUSY : DIV_BUSY;
                        end
                    end
                    MUL_BUSY: begin
                        if (r_vld_pipe[MUL_STAGES]) begin
                            r_hilo_result <= w_mul_res;
                            r_hilo_wen    <= 1'b1;
                            if (r_op == MUL) begin
                                r_gpr_result <= r_prod[MUL_STAGES-1][XLEN-1:0];
                                r_gpr_wen    <= 1'b1;
                            end
                            r_state <= DONE;
                        end
                    end
                    DIV_BUSY: begin
                        if (w_div_done) begin
                            r_hilo_result <= w_div_res;
                            r_hilo_wen    <= 1'b1;
                            r_state       <= DONE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE) || w_accept;
    assign hilo_wen    = r_hilo_wen & ~flush_i;
    assign gpr_wen     = r_gpr_wen & ~flush_i;
    assign hilo_result = r_hilo_result;
    assign gpr_result  = r_gpr_result;

endmodule
